// File: rtl/trap_sequencer_pkg.sv
// rtl/trap_sequencer_pkg.sv - trap codes, CSR map, mcause codes, mstatus fields and FSM encodings
package trap_sequencer_pkg;

  localparam logic [2:0] TRAP_NONE       = 3'd0;
  localparam logic [2:0] TRAP_ECALL      = 3'd1;
  localparam logic [2:0] TRAP_EBREAK     = 3'd2;
  localparam logic [2:0] TRAP_MISALIGNED = 3'd3;
  localparam logic [2:0] TRAP_FENCEI     = 3'd4;
  localparam logic [2:0] TRAP_MRET       = 3'd5;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam logic [30:0] CAUSE_MISALIGNED = 31'd0;
  localparam logic [30:0] CAUSE_EBREAK     = 31'd3;
  localparam logic [30:0] CAUSE_ECALL      = 31'd11;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_EPC      = 4'd1;
  localparam logic [3:0] ST_CAUSE    = 4'd2;
  localparam logic [3:0] ST_TVAL     = 4'd3;
  localparam logic [3:0] ST_MST_IN   = 4'd4;
  localparam logic [3:0] ST_TVEC     = 4'd5;
  localparam logic [3:0] ST_REDIR    = 4'd6;
  localparam logic [3:0] ST_HALT     = 4'd7;
  localparam logic [3:0] ST_FLUSH    = 4'd8;
  localparam logic [3:0] ST_FL_WAIT  = 4'd9;
  localparam logic [3:0] ST_MRET_ST  = 4'd10;
  localparam logic [3:0] ST_MRET_EPC = 4'd11;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] tval;
    logic [31:0] cause;
    logic        is_irq;
    logic [2:0]  code;
  } trap_ctx_t;

  function automatic logic [30:0] exc_cause(input logic [2:0] code);
    logic [30:0] c;
    case (code)
      TRAP_ECALL:  c = CAUSE_ECALL;
      TRAP_EBREAK: c = CAUSE_EBREAK;
      default:     c = CAUSE_MISALIGNED;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] mstatus_on_trap(input logic [31:0] s);
    logic [31:0] n;
    n = s;
    n[MSTATUS_MPIE] = s[MSTATUS_MIE];
    n[MSTATUS_MIE] = 1'b0;
    n[MSTATUS_MPP_LO +: 2] = 2'b11;
    return n;
  endfunction

  function automatic logic [31:0] mstatus_on_mret(input logic [31:0] s);
    logic [31:0] n;
    n = s;
    n[MSTATUS_MIE] = s[MSTATUS_MPIE];
    n[MSTATUS_MPIE] = 1'b1;
    n[MSTATUS_MPP_LO +: 2] = 2'b11;
    return n;
  endfunction

endpackage

// File: rtl/trap_irq_arbiter.sv
// rtl/trap_irq_arbiter.sv - masked fixed-priority interrupt encoder, lowest index wins
module trap_irq_arbiter #(
  parameter int NUM_IRQ = 16
) (
  input  logic [NUM_IRQ-1:0] pending,
  input  logic [NUM_IRQ-1:0] enable,
  output logic               valid,
  output logic [3:0]         idx
);

  logic [NUM_IRQ-1:0] masked;

  // Descending scan so the last hit, i.e. the lowest index, sticks.
  always_comb begin
    masked = pending & enable;
    valid  = |masked;
    idx    = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (masked[i]) idx = 4'(i);
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - machine-mode trap sequencer: CSR update sequence, redirect, debug halt, I-cache flush
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter int NUM_IRQ       = 16,
  parameter int IRQ_CODE_BASE = 16,
  parameter bit HAS_MTVAL     = 1'b1,
  parameter bit VECTORED      = 1'b1,
  parameter bit EBREAK_HALTS  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               trap_req,
  input  logic [2:0]         trap_status,
  input  logic [31:0]        pc,
  input  logic [31:0]        trap_tval,
  output logic               trap_ack,
  input  logic [NUM_IRQ-1:0] irq_pending,
  input  logic [NUM_IRQ-1:0] irq_enable,
  input  logic               mstatus_mie,
  input  logic               dbg_resume,
  input  logic               ic_done,
  output logic               busy,
  output logic               redirect_valid,
  output logic [31:0]        redirect_target,
  output logic               ic_clean,
  output logic               debug_mode,
  output logic [11:0]        csr_addr,
  output logic               csr_we,
  output logic [31:0]        csr_wdata,
  input  logic [31:0]        csr_rdata
);

  logic [3:0]  state;
  trap_ctx_t   ctx;
  logic [31:0] target;
  logic        debug_q;
  logic        done_q;
  logic        irq_valid;
  logic [3:0]  irq_idx;
  logic        req_ok;
  logic        irq_take;
  logic [31:0] irq_cause;
  logic [31:0] tvec_target;
  logic        we_s;

  trap_irq_arbiter #(.NUM_IRQ(NUM_IRQ)) u_arb (
    .pending (irq_pending),
    .enable  (irq_enable),
    .valid   (irq_valid),
    .idx     (irq_idx)
  );

  always_comb begin
    req_ok    = trap_req && (trap_status != TRAP_NONE) && (trap_status <= TRAP_MRET);
    irq_take  = mstatus_mie && irq_valid;
    irq_cause = {1'b1, 31'(IRQ_CODE_BASE) + 31'(irq_idx)};
    // Vectored offset is 4*cause[30:0]; bits above 29 fall off the 32-bit add.
    tvec_target = {csr_rdata[31:2], 2'b00};
    if (VECTORED && csr_rdata[1:0] == 2'b01 && ctx.is_irq)
      tvec_target = tvec_target + {ctx.cause[29:0], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      ctx     <= '0;
      target  <= '0;
      debug_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_ok) begin
            ctx.pc     <= pc;
            ctx.tval   <= trap_tval;
            ctx.cause  <= {1'b0, exc_cause(trap_status)};
            ctx.is_irq <= 1'b0;
            ctx.code   <= trap_status;
            case (trap_status)
              TRAP_FENCEI: state <= ST_FLUSH;
              TRAP_MRET:   state <= ST_MRET_ST;
              default:     state <= ST_EPC;
            endcase
          end else if (irq_take) begin
            ctx.pc     <= pc;
            ctx.tval   <= '0;
            ctx.cause  <= irq_cause;
            ctx.is_irq <= 1'b1;
            ctx.code   <= TRAP_NONE;
            state      <= ST_EPC;
          end
        end
        ST_EPC: state <= ST_CAUSE;
        ST_CAUSE: begin
          if (EBREAK_HALTS && !ctx.is_irq && ctx.code == TRAP_EBREAK) begin
            state   <= ST_HALT;
            debug_q <= 1'b1;
          end else begin
            state <= HAS_MTVAL ? ST_TVAL : ST_MST_IN;
          end
        end
        ST_TVAL:   state <= ST_MST_IN;
        ST_MST_IN: state <= ST_TVEC;
        ST_TVEC: begin
          target <= tvec_target;
          state  <= ST_REDIR;
        end
        ST_REDIR: state <= ST_IDLE;
        ST_HALT: begin
          if (dbg_resume) begin
            target <= ctx.pc + 32'd4;
            state  <= ST_REDIR;
          end
        end
        // A completion seen during the request cycle is remembered for FL_WAIT.
        ST_FLUSH: begin
          done_q <= ic_done;
          state  <= ST_FL_WAIT;
        end
        ST_FL_WAIT: begin
          if (ic_done || done_q) begin
            target <= ctx.pc + 32'd4;
            state  <= ST_REDIR;
          end
        end
        ST_MRET_ST: state <= ST_MRET_EPC;
        ST_MRET_EPC: begin
          target  <= csr_rdata & ~32'd3;
          debug_q <= 1'b0;
          state   <= ST_REDIR;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    csr_addr  = '0;
    csr_wdata = '0;
    we_s      = 1'b0;
    case (state)
      ST_EPC: begin
        csr_addr  = CSR_MEPC;
        csr_wdata = ctx.pc & ~32'd3;
        we_s      = 1'b1;
      end
      ST_CAUSE: begin
        csr_addr  = CSR_MCAUSE;
        csr_wdata = ctx.cause;
        we_s      = 1'b1;
      end
      ST_TVAL: begin
        csr_addr  = CSR_MTVAL;
        csr_wdata = ctx.is_irq ? 32'd0 : ctx.tval;
        we_s      = 1'b1;
      end
      ST_MST_IN: begin
        csr_addr  = CSR_MSTATUS;
        csr_wdata = mstatus_on_trap(csr_rdata);
        we_s      = 1'b1;
      end
      ST_TVEC:  csr_addr = CSR_MTVEC;
      ST_MRET_ST: begin
        csr_addr  = CSR_MSTATUS;
        csr_wdata = mstatus_on_mret(csr_rdata);
        we_s      = 1'b1;
      end
      ST_MRET_EPC: csr_addr = CSR_MEPC;
      default: ;
    endcase
  end

  assign csr_we          = we_s && !rst;
  assign trap_ack        = (state == ST_IDLE) && req_ok && !rst;
  assign busy            = (state != ST_IDLE);
  assign redirect_valid  = (state == ST_REDIR) && !rst;
  assign redirect_target = (state == ST_REDIR) ? target : 32'd0;
  assign ic_clean        = (state == ST_FLUSH) && !rst;
  assign debug_mode      = debug_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// tb/tb_trap_sequencer.sv - trap_sequencer bench: transaction-level expected-output model with per-cycle compare
module tb_trap_sequencer;

  localparam int NUM_IRQ       = 16;
  localparam int IRQ_CODE_BASE = 16;
  localparam bit HAS_MTVAL     = 1'b1;
  localparam bit VECTORED      = 1'b1;
  localparam bit EBREAK_HALTS  = 1'b1;

  logic        clk, rst, trap_req, trap_ack, mstatus_mie, dbg_resume, ic_done;
  logic [2:0]  trap_status;
  logic [31:0] pc, trap_tval, redirect_target, csr_wdata, csr_rdata;
  logic [NUM_IRQ-1:0] irq_pending, irq_enable;
  logic        busy, redirect_valid, ic_clean, debug_mode, csr_we;
  logic [11:0] csr_addr;

  trap_sequencer #(
    .NUM_IRQ(NUM_IRQ), .IRQ_CODE_BASE(IRQ_CODE_BASE), .HAS_MTVAL(HAS_MTVAL),
    .VECTORED(VECTORED), .EBREAK_HALTS(EBREAK_HALTS)
  ) dut (
    .clk(clk), .rst(rst), .trap_req(trap_req), .trap_status(trap_status), .pc(pc),
    .trap_tval(trap_tval), .trap_ack(trap_ack), .irq_pending(irq_pending),
    .irq_enable(irq_enable), .mstatus_mie(mstatus_mie), .dbg_resume(dbg_resume),
    .ic_done(ic_done), .busy(busy), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .ic_clean(ic_clean), .debug_mode(debug_mode),
    .csr_addr(csr_addr), .csr_we(csr_we), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CSR file environment
  logic [31:0] csr_mstatus = 32'h8;
  logic [31:0] csr_mepc = 32'h0, csr_mcause = 32'h0, csr_mtval = 32'h0;
  logic [31:0] csr_mtvec;

  always_comb begin
    case (csr_addr)
      12'h300: csr_rdata = csr_mstatus;
      12'h305: csr_rdata = csr_mtvec;
      12'h341: csr_rdata = csr_mepc;
      12'h342: csr_rdata = csr_mcause;
      12'h343: csr_rdata = csr_mtval;
      default: csr_rdata = 32'h0;
    endcase
  end
  assign mstatus_mie = csr_mstatus[3];

  always @(posedge clk) begin
    if (csr_we) begin
      case (csr_addr)
        12'h300: csr_mstatus <= csr_wdata;
        12'h341: csr_mepc    <= csr_wdata;
        12'h342: csr_mcause  <= csr_wdata;
        12'h343: csr_mtval   <= csr_wdata;
        default: ;
      endcase
    end
  end

  typedef struct packed {
    logic        busy, ack, we, chk;
    logic [11:0] addr;
    logic [31:0] wd;
    logic        rv;
    logic [31:0] tgt;
    logic        icl, dbg, rst_only;
  } exp_t;

  // Model state (written only by the stimulus process)
  logic [31:0] m_mstatus = 32'h8;
  logic [31:0] m_mepc = 32'h0;
  logic [31:0] m_mtvec;
  logic        m_debug = 1'b0;
  exp_t        exp_arr [0:8191];
  int          exp_wr = 0;
  string       lit_name [0:255];
  logic [31:0] lit_got [0:255];
  logic [31:0] lit_exp [0:255];
  int          lit_wr = 0;
  int          txn_start = 0;

  // Compare-process state
  int          exp_rd = 0, lit_rd = 0;
  int          n_vec = 0, n_err = 0, cyc = 0, redir_cyc = 0, ic_cnt = 0;
  logic [31:0] redir_tgt = 32'h0;

  function automatic exp_t mk(logic b, logic a, logic w, logic c, logic [11:0] ad,
                              logic [31:0] wd, logic rv, logic [31:0] tg, logic icl, logic dbg);
    exp_t e;
    e.busy = b; e.ack = a; e.we = w; e.chk = c; e.addr = ad; e.wd = wd;
    e.rv = rv; e.tgt = tg; e.icl = icl; e.dbg = dbg; e.rst_only = 1'b0;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    logic ok;
    cyc = cyc + 1;
    if (redirect_valid) begin
      redir_cyc = cyc;
      redir_tgt = redirect_target;
    end
    if (ic_clean) ic_cnt = ic_cnt + 1;
    if (exp_rd < exp_wr) begin
      e = exp_arr[exp_rd];
      exp_rd = exp_rd + 1;
    end else begin
      e = mk(0, 0, 0, 0, 12'h0, 32'h0, 0, 32'h0, 0, m_debug);
    end
    n_vec = n_vec + 1;
    if (e.rst_only)
      ok = !csr_we && !redirect_valid;
    else
      ok = busy === e.busy && trap_ack === e.ack && csr_we === e.we &&
           (!e.chk || csr_addr === e.addr) && (!e.we || csr_wdata === e.wd) &&
           redirect_valid === e.rv && (!e.rv || redirect_target === e.tgt) &&
           ic_clean === e.icl && debug_mode === e.dbg;
    if (!ok) begin
      n_err = n_err + 1;
      $display("FAIL cycle %0d outputs: got busy=%b ack=%b we=%b addr=%h wdata=%h rv=%b tgt=%h icl=%b dbg=%b; required busy=%b ack=%b we=%b addr=%h wdata=%h rv=%b tgt=%h icl=%b dbg=%b rst_only=%b",
               cyc, busy, trap_ack, csr_we, csr_addr, csr_wdata, redirect_valid, redirect_target,
               ic_clean, debug_mode, e.busy, e.ack, e.we, e.addr, e.wd, e.rv, e.tgt, e.icl, e.dbg, e.rst_only);
    end
    while (lit_rd < lit_wr) begin
      n_vec = n_vec + 1;
      if (lit_got[lit_rd] !== lit_exp[lit_rd]) begin
        n_err = n_err + 1;
        $display("FAIL %s: got %h required %h", lit_name[lit_rd], lit_got[lit_rd], lit_exp[lit_rd]);
      end
      lit_rd = lit_rd + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input exp_t e);
    exp_arr[exp_wr] = e;
    exp_wr = exp_wr + 1;
  endtask

  task automatic lit(input string n, input logic [31:0] got, input logic [31:0] want);
    lit_name[lit_wr] = n;
    lit_got[lit_wr]  = got;
    lit_exp[lit_wr]  = want;
    lit_wr = lit_wr + 1;
  endtask

  // One transaction: d = halt cycles (EBREAK) or ic_done offset from accept (FENCEI).
  task automatic run_txn(input logic req, input logic [2:0] code, input logic [31:0] tpc,
                         input logic [31:0] ttval, input logic [15:0] ip, input logic [15:0] ie,
                         input int d);
    logic        valid, irq, found;
    logic [15:0] pm;
    logic [31:0] cause, tgt, ms;
    int          idx, first, len, resume_at, done_at, wait_end;
    txn_start = cyc;
    first = exp_wr;
    resume_at = -1;
    done_at = -1;
    idx = 0;
    valid = req && code >= 3'd1 && code <= 3'd5;
    pm = ip & ie;
    irq = !valid && m_mstatus[3] && pm != 16'h0;
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!found && pm[i]) begin
        idx = i;
        found = 1'b1;
      end
    end
    if (!valid && !irq) begin
      push(mk(0, 0, 0, 0, 12'h0, 32'h0, 0, 32'h0, 0, m_debug));
    end else if (valid && code == 3'd5) begin
      push(mk(0, 1, 0, 0, 12'h0, 32'h0, 0, 32'h0, 0, m_debug));
      ms = m_mstatus;
      ms[3] = m_mstatus[7];
      ms[7] = 1'b1;
      ms[12:11] = 2'b11;
      push(mk(1, 0, 1, 1, 12'h300, ms, 0, 32'h0, 0, m_debug));
      m_mstatus = ms;
      push(mk(1, 0, 0, 1, 12'h341, 32'h0, 0, 32'h0, 0, m_debug));
      m_debug = 1'b0;
      push(mk(1, 0, 0, 0, 12'h0, 32'h0, 1, m_mepc & ~32'd3, 0, m_debug));
    end else if (valid && code == 3'd4) begin
      push(mk(0, 1, 0, 0, 12'h0, 32'h0, 0, 32'h0, 0, m_debug));
      push(mk(1, 0, 0, 0, 12'h0, 32'h0, 0, 32'h0, 1, m_debug));
      wait_end = (d > 2) ? d : 2;
      for (int c = 2; c <= wait_end; c++) push(mk(1, 0, 0, 0, 12'h0, 32'h0, 0, 32'h0, 0, m_debug));
      push(mk(1, 0, 0, 0, 12'h0, 32'h0, 1, tpc + 32'd4, 0, m_debug));
      done_at = d;
    end else begin
      if (irq) cause = 32'h8000_0000 + 32'(IRQ_CODE_BASE + idx);
      else if (code == 3'd1) cause = 32'd11;
      else if (code == 3'd2) cause = 32'd3;
      else cause = 32'd0;
      push(mk(0, !irq, 0, 0, 12'h0, 32'h0, 0, 32'h0, 0, m_debug));
      push(mk(1, 0, 1, 1, 12'h341, tpc & ~32'd3, 0, 32'h0, 0, m_debug));
      m_mepc = tpc & ~32'd3;
      push(mk(1, 0, 1, 1, 12'h342, cause, 0, 32'h0, 0, m_debug));
      if (EBREAK_HALTS && !irq && code == 3'd2) begin
        m_debug = 1'b1;
        for (int c = 0; c < d; c++) push(mk(1, 0, 0, 0, 12'h0, 32'h0, 0, 32'h0, 0, m_debug));
        resume_at = 3 + d - 1;
        push(mk(1, 0, 0, 0, 12'h0, 32'h0, 1, tpc + 32'd4, 0, m_debug));
      end else begin
        if (HAS_MTVAL) push(mk(1, 0, 1, 1, 12'h343, irq ? 32'h0 : ttval, 0, 32'h0, 0, m_debug));
        ms = m_mstatus;
        ms[7] = m_mstatus[3];
        ms[3] = 1'b0;
        ms[12:11] = 2'b11;
        push(mk(1, 0, 1, 1, 12'h300, ms, 0, 32'h0, 0, m_debug));
        m_mstatus = ms;
        push(mk(1, 0, 0, 1, 12'h305, 32'h0, 0, 32'h0, 0, m_debug));
        tgt = m_mtvec - (m_mtvec % 32'd4);
        if (VECTORED && (m_mtvec % 32'd4) == 32'd1 && irq) tgt = tgt + 32'd4 * (cause % 32'h8000_0000);
        push(mk(1, 0, 0, 0, 12'h0, 32'h0, 1, tgt, 0, m_debug));
      end
    end
    len = exp_wr - first;
    for (int c = 0; c < len; c++) begin
      trap_req    = req && (c == 0);
      trap_status = code;
      pc          = tpc;
      trap_tval   = ttval;
      irq_pending = ip;
      irq_enable  = ie;
      dbg_resume  = (c == resume_at);
      ic_done     = (c == done_at);
      tick();
    end
    trap_req    = 1'b0;
    dbg_resume  = 1'b0;
    ic_done     = 1'b0;
    irq_pending = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1);
  end

  initial begin
    int ic0;
    logic [31:0] mtval0;
    logic [2:0] rc;
    logic rq;
    rst = 1'b1;
    trap_req = 1'b0; trap_status = 3'd0; pc = 32'h0; trap_tval = 32'h0;
    irq_pending = '0; irq_enable = '0; dbg_resume = 1'b0; ic_done = 1'b0;
    csr_mtvec = 32'h800;
    m_mtvec = 32'h800;
    tick(); tick(); tick();
    lit("reset busy", {31'h0, busy}, 32'h0);
    lit("reset csr_addr", {20'h0, csr_addr}, 32'h0);
    rst = 1'b0;
    tick();

    run_txn(1, 3'd1, 32'h100, 32'h0, 16'h0, 16'h0, 0);
    lit("ecall redirect", redir_tgt, 32'h800);
    lit("ecall latency", 32'(redir_cyc - txn_start - 1), 32'd6);
    lit("ecall mepc", csr_mepc, 32'h100);
    lit("ecall mcause", csr_mcause, 32'd11);
    lit("ecall mtval", csr_mtval, 32'h0);
    lit("ecall mstatus mie/mpie", {30'h0, csr_mstatus[3], csr_mstatus[7]}, 32'h1);

    run_txn(1, 3'd5, 32'h0, 32'h0, 16'h0, 16'h0, 0);
    lit("mret redirect", redir_tgt, 32'h100);

    csr_mtvec = 32'h801;
    m_mtvec = 32'h801;
    run_txn(0, 3'd0, 32'h300, 32'h0, 16'h0004, 16'hffff, 0);
    lit("irq2 mcause", csr_mcause, 32'h8000_0012);
    lit("irq2 vectored redirect", redir_tgt, 32'h848);

    run_txn(1, 3'd5, 32'h0, 32'h0, 16'h0, 16'h0, 0);
    run_txn(1, 3'd3, 32'h404, 32'h1002, 16'h0002, 16'hffff, 0);
    lit("misaligned beats irq mcause", csr_mcause, 32'h0);
    lit("misaligned mtval", csr_mtval, 32'h1002);
    run_txn(1, 3'd5, 32'h0, 32'h0, 16'h0002, 16'hffff, 0);
    lit("mret after misaligned", redir_tgt, 32'h404);
    run_txn(0, 3'd0, 32'h408, 32'h0, 16'h0002, 16'hffff, 0);
    lit("deferred irq1 mcause", csr_mcause, 32'h8000_0011);
    lit("deferred irq1 redirect", redir_tgt, 32'h844);

    run_txn(1, 3'd5, 32'h0, 32'h0, 16'h0, 16'h0, 0);
    csr_mtvec = 32'h800;
    m_mtvec = 32'h800;
    run_txn(1, 3'd2, 32'h200, 32'h0, 16'h0, 16'h0, 51);
    lit("ebreak debug_mode", {31'h0, debug_mode}, 32'h1);
    lit("ebreak resume redirect", redir_tgt, 32'h204);
    run_txn(1, 3'd5, 32'h0, 32'h0, 16'h0, 16'h0, 0);
    lit("mret clears debug_mode", {31'h0, debug_mode}, 32'h0);

    ic0 = ic_cnt;
    run_txn(1, 3'd4, 32'h40, 32'h0, 16'h0, 16'h0, 7);
    lit("fencei ic_clean pulses", 32'(ic_cnt - ic0), 32'd1);
    lit("fencei redirect", redir_tgt, 32'h44);
    lit("fencei latency", 32'(redir_cyc - txn_start - 1), 32'd8);

    // Reset during the TVAL cycle of an ECALL
    mtval0 = csr_mtval;
    txn_start = cyc;
    push(mk(0, 1, 0, 0, 12'h0, 32'h0, 0, 32'h0, 0, m_debug));
    push(mk(1, 0, 1, 1, 12'h341, 32'h500, 0, 32'h0, 0, m_debug));
    push(mk(1, 0, 1, 1, 12'h342, 32'd11, 0, 32'h0, 0, m_debug));
    begin
      exp_t e;
      e = mk(0, 0, 0, 0, 12'h0, 32'h0, 0, 32'h0, 0, 0);
      e.rst_only = 1'b1;
      push(e);
    end
    m_mepc = 32'h500;
    trap_req = 1'b1; trap_status = 3'd1; pc = 32'h500; trap_tval = 32'h77;
    tick();
    trap_req = 1'b0;
    tick(); tick();
    rst = 1'b1;
    m_debug = 1'b0;
    tick();
    rst = 1'b0;
    tick(); tick();
    lit("reset abandons mtval write", csr_mtval, mtval0);
    lit("reset abandons mstatus write", csr_mstatus, m_mstatus);

    for (int t = 0; t < 100; t++) begin
      rc = 3'($urandom_range(0, 7));
      rq = (rc != 3'd0) || ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) begin
        m_mtvec = {$urandom, 2'b00} | 32'($urandom_range(0, 1));
        csr_mtvec = m_mtvec;
      end
      run_txn(rq, rc, $urandom, $urandom,
              ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'h0, 16'($urandom),
              $urandom_range(1, 6));
    end

    tick(); tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
